// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the RV32 multi-cycle sequencer: state codes and defaults.
package cpu_seq_pkg;

    // Sequencer state codes; they appear unchanged on the debug state output.
    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } seq_state_e;

    localparam int unsigned CNT_W_DEFAULT   = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned TO_W_DEFAULT    = 8;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts un-acknowledged memory wait cycles and flags the cycle that would
// reach the TIMEOUT limit. TIMEOUT=0 disables expiry. 2^TO_W must exceed TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expired
);

    localparam logic [TO_W:0] LIMIT  = (TO_W+1)'(TIMEOUT);
    localparam logic [TO_W:0] ONE_W  = (TO_W+1)'(1);
    localparam logic          TO_ON  = (TIMEOUT != 32'd0);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    // Expiry fires in the cycle whose un-acked increment would hit the limit;
    // an ack in that same cycle takes priority.
    always_comb begin
        cnt_d   = cnt_q;
        expired = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !ack) begin
            cnt_d = cnt_q + TO_W'(1);
        end
        if (TO_ON && en && !ack && (({1'b0, cnt_q} + ONE_W) == LIMIT)) begin
            expired = 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle sequencer: steps the datapath through FETCH/DECODE/EXEC/MEM/WB,
// owns run/step/halt control, the memory req/ack wait with timeout, and the
// committed-instruction and active-cycle counters.
// Memory handshake: mem_req stays high in FETCH/MEM until a cycle with mem_ack=1;
// that cycle completes the request, and mem_ack is ignored in every other state.
module multicycle_seq
    import cpu_seq_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = TO_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             dec_rf_we,
    input  logic             dec_mem_we,
    input  logic             dec_load,
    input  logic             dec_ebreak,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] inst_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    seq_state_e       state_q, state_d;
    logic             run_mode_q, run_mode_d;
    logic             halt_pend_q, halt_pend_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    logic waiting;
    logic to_expired;

    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

    // One timer serves both FETCH and MEM; it is held clear in every other state,
    // so it always starts from zero when either wait state is entered.
    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (!waiting),
        .en      (waiting),
        .ack     (mem_ack),
        .expired (to_expired)
    );

    // Next-state, datapath enables and counter updates.
    always_comb begin
        state_d     = state_q;
        run_mode_d  = run_mode_q;
        err_d       = err_q;
        inst_cnt_d  = inst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        halt_pend_d = halt_pend_q;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;

        case (state_q)
            ST_HALT: begin
                halted = 1'b1;
                if (run) begin
                    state_d    = ST_FETCH;
                    run_mode_d = 1'b1;
                    err_d      = 1'b0;
                end else if (step) begin
                    state_d    = ST_FETCH;
                    run_mode_d = 1'b0;
                    err_d      = 1'b0;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (to_expired) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_DECODE: begin
                state_d = dec_ebreak ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                state_d = (dec_load || dec_mem_we) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_wr  = dec_mem_we;
                if (mem_ack) begin
                    state_d = ST_WB;
                end else if (to_expired) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end
            end
            ST_WB: begin
                rf_we      = dec_rf_we;
                pc_we      = 1'b1;
                inst_cnt_d = inst_cnt_q + CNT_W'(1);
                if (run_mode_q && !halt_req && !halt_pend_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (state_q != ST_HALT) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end

        // A halt request is remembered until the sequencer actually stops.
        if (state_d == ST_HALT) begin
            halt_pend_d = 1'b0;
        end else if (state_q != ST_HALT && halt_req) begin
            halt_pend_d = 1'b1;
        end
    end

    // State and counter registers; reset parks the sequencer in HALT.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_HALT;
            run_mode_q  <= 1'b0;
            halt_pend_q <= 1'b0;
            err_q       <= 1'b0;
            inst_cnt_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            run_mode_q  <= run_mode_d;
            halt_pend_q <= halt_pend_d;
            err_q       <= err_d;
            inst_cnt_q  <= inst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign state     = state_q;
    assign err       = err_q;
    assign inst_cnt  = inst_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: per-cycle vector table plus hand-written
// counter checkpoints and an asynchronous reset during a memory wait.
module tb_multicycle_seq;

    // Row inputs  in  = {run, step, halt_req, dec_rf_we, dec_mem_we, dec_load, dec_ebreak, mem_ack}
    // Row outputs out = {mem_req, mem_wr, ir_we, pc_we, rf_we, halted, err}
    typedef struct {
        logic [7:0] in;
        logic [2:0] st;
        logic [6:0] out;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        run, step, halt_req;
    logic        dec_rf_we, dec_mem_we, dec_load, dec_ebreak;
    logic        mem_ack;
    logic        mem_req, mem_wr, ir_we, pc_we, rf_we, halted, err;
    logic [2:0]  state;
    logic [31:0] inst_cnt, cycle_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int row_id = 0;
    vec_t tbl[$];

    multicycle_seq #(
        .CNT_W   (32),
        .TIMEOUT (4),
        .TO_W    (3)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .step       (step),
        .halt_req   (halt_req),
        .dec_rf_we  (dec_rf_we),
        .dec_mem_we (dec_mem_we),
        .dec_load   (dec_load),
        .dec_ebreak (dec_ebreak),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .inst_cnt   (inst_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t v(input logic [7:0] in, input logic [2:0] st, input logic [6:0] out);
        vec_t r;
        r.in  = in;
        r.st  = st;
        r.out = out;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0h, want %0h", nm, row_id, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, check before the rising edge.
    task automatic apply(input vec_t r);
        @(negedge clk);
        {run, step, halt_req, dec_rf_we, dec_mem_we, dec_load, dec_ebreak, mem_ack} = r.in;
        #1;
        chk("state",   {29'd0, state},   {29'd0, r.st});
        chk("mem_req", {31'd0, mem_req}, {31'd0, r.out[6]});
        chk("mem_wr",  {31'd0, mem_wr},  {31'd0, r.out[5]});
        chk("ir_we",   {31'd0, ir_we},   {31'd0, r.out[4]});
        chk("pc_we",   {31'd0, pc_we},   {31'd0, r.out[3]});
        chk("rf_we",   {31'd0, rf_we},   {31'd0, r.out[2]});
        chk("halted",  {31'd0, halted},  {31'd0, r.out[1]});
        chk("err",     {31'd0, err},     {31'd0, r.out[0]});
        row_id++;
    endtask

    task automatic run_tbl();
        while (tbl.size() > 0) apply(tbl.pop_front());
    endtask

    // Let the last row's rising edge happen, then check the counters.
    task automatic chk_cnt(input logic [31:0] exp_inst, input logic [31:0] exp_cyc);
        @(posedge clk);
        #1;
        chk("inst_cnt",  inst_cnt,  exp_inst);
        chk("cycle_cnt", cycle_cnt, exp_cyc);
    endtask

    initial begin
        rstn = 1'b0;
        {run, step, halt_req, dec_rf_we, dec_mem_we, dec_load, dec_ebreak, mem_ack} = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_state",  {29'd0, state}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_outs",   {25'd0, mem_req, mem_wr, ir_we, pc_we, rf_we, err, 1'b0}, 32'd0);
        chk("rst_inst",   inst_cnt, 32'd0);
        chk("rst_cycle",  cycle_cnt, 32'd0);
        rstn = 1'b1;

        // Free-run ALU program with mem_ack tied high (ignored outside FETCH/MEM).
        tbl.push_back(v(8'b1000_0001, 3'd0, 7'b0000010));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(v(8'b1000_0001, 3'd1, 7'b1010000));
            tbl.push_back(v(8'b1001_0001, 3'd2, 7'b0000000));
            tbl.push_back(v(8'b1001_0001, 3'd3, 7'b0000000));
            tbl.push_back(v(8'b1001_0001, 3'd5, 7'b0001100));
        end
        run_tbl();
        chk_cnt(32'd3, 32'd12);

        // Store in free-run; halt_req pulse in EXEC lets it commit, then HALT.
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0000_1000, 3'd2, 7'b0000000));
        tbl.push_back(v(8'b0010_1000, 3'd3, 7'b0000000));
        tbl.push_back(v(8'b0000_1001, 3'd4, 7'b1100000));
        tbl.push_back(v(8'b0000_1000, 3'd5, 7'b0001000));
        run_tbl();
        chk_cnt(32'd4, 32'd17);

        // Single-step load with ack two cycles late in MEM: 7 active cycles.
        tbl.push_back(v(8'b0100_0000, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0001_0100, 3'd2, 7'b0000000));
        tbl.push_back(v(8'b0001_0100, 3'd3, 7'b0000000));
        tbl.push_back(v(8'b0001_0100, 3'd4, 7'b1000000));
        tbl.push_back(v(8'b0001_0100, 3'd4, 7'b1000000));
        tbl.push_back(v(8'b0001_0101, 3'd4, 7'b1000000));
        tbl.push_back(v(8'b0001_0100, 3'd5, 7'b0001100));
        run_tbl();
        chk_cnt(32'd5, 32'd24);

        // ebreak: DECODE goes straight to HALT, nothing commits.
        tbl.push_back(v(8'b0100_0000, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0000_0010, 3'd2, 7'b0000000));
        run_tbl();
        chk_cnt(32'd5, 32'd26);

        // Fetch timeout after 4 un-acked cycles, then a run that clears err and
        // an ack landing exactly on the limit cycle, which must win.
        tbl.push_back(v(8'b1000_0000, 3'd0, 7'b0000010));
        for (int i = 0; i < 4; i++) tbl.push_back(v(8'b0000_0000, 3'd1, 7'b1000000));
        tbl.push_back(v(8'b1000_0000, 3'd0, 7'b0000011));
        for (int i = 0; i < 3; i++) tbl.push_back(v(8'b0000_0000, 3'd1, 7'b1000000));
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0000_0000, 3'd2, 7'b0000000));
        tbl.push_back(v(8'b0000_0000, 3'd3, 7'b0000000));
        tbl.push_back(v(8'b0010_0000, 3'd5, 7'b0001000));
        run_tbl();
        chk_cnt(32'd6, 32'd37);

        // Idle HALT ignores ack/decoder/halt_req; then a load stopped by reset in MEM.
        tbl.push_back(v(8'b0011_1111, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0000_0000, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0100_0000, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0000_0100, 3'd2, 7'b0000000));
        tbl.push_back(v(8'b0000_0100, 3'd3, 7'b0000000));
        tbl.push_back(v(8'b0000_0100, 3'd4, 7'b1000000));
        run_tbl();
        #1 rstn = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("arst_state",   {29'd0, state},   32'd0);
        chk("arst_halted",  {31'd0, halted},  32'd1);
        chk("arst_inst",    inst_cnt,         32'd0);
        chk("arst_cycle",   cycle_cnt,        32'd0);
        @(negedge clk);
        {run, step, halt_req, dec_rf_we, dec_mem_we, dec_load, dec_ebreak, mem_ack} = 8'd0;
        rstn = 1'b1;

        // Stepped ALU instruction after reset: counters restart from zero.
        tbl.push_back(v(8'b0100_0000, 3'd0, 7'b0000010));
        tbl.push_back(v(8'b0000_0001, 3'd1, 7'b1010000));
        tbl.push_back(v(8'b0001_0000, 3'd2, 7'b0000000));
        tbl.push_back(v(8'b0001_0000, 3'd3, 7'b0000000));
        tbl.push_back(v(8'b0001_0000, 3'd5, 7'b0001100));
        run_tbl();
        chk_cnt(32'd1, 32'd4);
        chk("final_halted", {31'd0, halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
